// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if: lock/restart inputs and staged reset outputs of the reset sequencer
interface reset_sequencer_if #(
    parameter int NUM_STAGES = 3
);
    logic                  lock;
    logic                  soft_req;
    logic [NUM_STAGES-1:0] rst_out;
    logic                  done;
    logic [7:0]            restarts;

    modport master (output lock, soft_req, input rst_out, done, restarts);
    modport slave  (input lock, soft_req, output rst_out, done, restarts);
endinterface

// File: rtl/reset_sequencer.sv
// reset_sequencer: staged reset release after stable lock; RESET_SEQ_LOCKLOSS_EN makes lock loss outside HOLD restart the sequence
module reset_sequencer #(
    parameter int NUM_STAGES  = 3,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 8
) (
    input logic              clk,
    input logic              rst,
    reset_sequencer_if.slave bus
);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int GW = $clog2(STAGE_GAP + 1);
    localparam int IW = $clog2(NUM_STAGES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(STAGE_GAP - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_STAGES - 1);

    typedef enum logic [1:0] {HOLD, RELEASE, RUN} state_t;

    state_t                state, state_d;
    logic [HW-1:0]         hold_cnt, hold_d;
    logic [GW-1:0]         gap_cnt, gap_d;
    logic [IW-1:0]         idx, idx_d;
    logic [NUM_STAGES-1:0] rst_out, rst_out_d;
    logic                  done, done_d;
    logic [7:0]            restarts, restarts_d;
    logic                  restart;

`ifdef RESET_SEQ_LOCKLOSS_EN
    assign restart = bus.soft_req || (!bus.lock && state != HOLD);
`else
    assign restart = bus.soft_req;
`endif

    assign bus.rst_out  = rst_out;
    assign bus.done     = done;
    assign bus.restarts = restarts;

    // State and output registers; rst overrides everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= HOLD;
            hold_cnt <= '0;
            gap_cnt  <= '0;
            idx      <= '0;
            rst_out  <= '1;
            done     <= 1'b0;
            restarts <= '0;
        end else begin
            state    <= state_d;
            hold_cnt <= hold_d;
            gap_cnt  <= gap_d;
            idx      <= idx_d;
            rst_out  <= rst_out_d;
            done     <= done_d;
            restarts <= restarts_d;
        end
    end

    // Next state: restart wins, then lock qualification in HOLD, then gap-timed stage release
    always_comb begin
        state_d    = state;
        hold_d     = hold_cnt;
        gap_d      = gap_cnt;
        idx_d      = idx;
        rst_out_d  = rst_out;
        done_d     = done;
        restarts_d = restarts;
        if (restart) begin
            state_d    = HOLD;
            hold_d     = '0;
            gap_d      = '0;
            idx_d      = '0;
            rst_out_d  = '1;
            done_d     = 1'b0;
            restarts_d = (restarts == 8'hff) ? restarts : restarts + 8'd1;
        end else if (state == HOLD) begin
            hold_d = bus.lock ? hold_cnt + 1'b1 : '0;
            if (bus.lock && hold_cnt == HOLD_LAST) begin
                hold_d       = '0;
                gap_d        = '0;
                idx_d        = IW'(1);
                rst_out_d[0] = 1'b0;
                done_d       = (NUM_STAGES == 1);
                state_d      = (NUM_STAGES == 1) ? RUN : RELEASE;
            end
        end else if (state == RELEASE) begin
            gap_d = gap_cnt + 1'b1;
            if (gap_cnt == GAP_LAST) begin
                gap_d     = '0;
                idx_d     = idx + 1'b1;
                rst_out_d = rst_out & ~(NUM_STAGES'(1) << idx);
                if (idx == IDX_LAST) begin
                    done_d  = 1'b1;
                    state_d = RUN;
                end
            end
        end
    end
endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Staged reset release for the FPGA fabric. Consumes the global power-on `rst` from the synchronous reset generator plus a clock-lock indication and a software restart request. Holds every subsystem reset asserted until lock has been stable, then releases `NUM_STAGES` reset outputs one after another with a fixed gap. Sits between the global reset source and the per-subsystem reset inputs (capture, buffering, host interface).

## Interface
- `NUM_STAGES`, default 3: number of staged reset outputs, legal range 1..8.
- `HOLD_CYCLES`, default 16: consecutive lock-high edges required before stage 0 releases, minimum 1.
- `STAGE_GAP`, default 8: edges between successive stage releases, minimum 1.
- `clk  input  1`: fabric clock; the only clock.
- `rst  input  1`: synchronous, active-high reset (from the reset generator).
- `lock  input  1`: clock/PLL lock; already synchronous to `clk`.
- `soft_req  input  1`: single-cycle software restart request.
- `rst_out  output  NUM_STAGES`: per-stage resets, active-high; bit 0 releases first.
- `done  output  1`: high when all stages are released.
- `restarts  output  8`: saturating count of sequence restarts.

## Operation
- States: HOLD, RELEASE, RUN.
- `rst`=1 at an edge:
  - next state HOLD;
  - `rst_out` all ones, `done`=0, `restarts`=0;
  - hold counter and gap counter cleared.
- `rst` beats every other input, in every state.
- HOLD:
  - `hold_cnt` increments on each edge with `lock`=1 and clears to 0 on any edge with `lock`=0.
  - On the edge where `lock`=1 and `hold_cnt`==HOLD_CYCLES-1: go to RELEASE, clear `rst_out[0]`, clear `gap_cnt`, set stage index to 1.
  - `hold_cnt` width is clog2(HOLD_CYCLES+1).
- RELEASE:
  - `gap_cnt` increments every edge.
  - When `gap_cnt`==STAGE_GAP-1: clear `rst_out[idx]`, increment idx, clear `gap_cnt`.
  - The edge that clears `rst_out[NUM_STAGES-1]` also sets `done`=1 and moves to RUN.
  - NUM_STAGES=1 goes from HOLD straight to RUN, with `done` set on the same edge as the release.
- RUN: outputs are stable.
- `soft_req`=1 (and `rst`=0) in any state:
  - next state HOLD;
  - `rst_out` all ones, `done`=0, counters cleared;
  - `restarts` increments, saturating at 255.
  - `soft_req` beats the lock and counter transitions on the same edge.
- Released bits never re-assert except through a return to HOLD.
- Lock-loss behaviour is set under Configuration.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- Edge numbering below counts from edge 1, the first edge with `rst`=0. `lock`=1 is held from edge 1.
  - `rst_out[0]` falls at edge HOLD_CYCLES.
  - `rst_out[i]` falls at edge HOLD_CYCLES + i·STAGE_GAP.
  - `done` rises together with the last stage release.
- The return to HOLD (on `soft_req`, lock loss or `rst`) takes effect on the edge that samples the event. Outputs are all asserted in the following cycle.
- `lock` dropping in HOLD for even one edge restarts the full HOLD_CYCLES count.

## Configuration
- `RESET_SEQ_LOCKLOSS_EN` defined:
  - `lock`=0 sampled in RELEASE or RUN acts like `soft_req`: return to HOLD and assert all outputs.
  - `restarts` increments.
- Not defined:
  - `lock` is ignored outside HOLD.
  - Only `rst` and `soft_req` restart the sequence.

## Test plan
- Default params, `lock`=1 from edge 1: `rst_out` falls 3'b110 at edge 16, 3'b100 at 24, 3'b000 at 32; `done`=1 at 32; `restarts`=0.
- `lock` toggles low at edge 10, high again from edge 11: `rst_out[0]` falls at edge 26, not 16.
- `soft_req` pulse at edge 20, while mid-RELEASE: `rst_out`=3'b111 and `done`=0 in the next cycle; `restarts`=1; `rst_out[0]` re-releases 16 edges later.
- `rst` and `soft_req` both high at edge 40 in RUN: full reset, `restarts`=0.
- With `RESET_SEQ_LOCKLOSS_EN`, `lock` drops in RUN: all resets assert and `restarts` increments. Without the macro, outputs are unchanged.
- NUM_STAGES=1, HOLD_CYCLES=1: `rst_out` and `done` both change at edge 1. Also check 255 `soft_req` pulses followed by one more: `restarts` stays 255.
